// File: rtl/alu6.sv
// Registered two's-complement ALU: four adder-based arithmetic ops and four bitwise ops,
// with a registered signed-overflow flag that is only meaningful for the arithmetic group.
module alu6 #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] res,
  output logic             err
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_DEC = 3'b010;
  localparam logic [2:0] OP_INC = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] bm_s;
  logic signed [WIDTH-1:0] sum_s;
  logic                    cin;
  logic signed [WIDTH-1:0] res_d;
  logic signed [WIDTH-1:0] res_q;
  logic                    err_d;
  logic                    err_q;

  // Same-sign adder inputs producing an opposite-sign sum; equals carry-in(MSB) ^ carry-out(MSB).
  function automatic logic ovf_f(input logic signed [WIDTH-1:0] x,
                                 input logic signed [WIDTH-1:0] y,
                                 input logic signed [WIDTH-1:0] s);
    ovf_f = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  assign a_s = $signed(a);

  // Operand-B mux and carry-in for the single shared adder.
  always_comb begin
    bm_s = '0;
    cin  = 1'b0;
    case (op)
      OP_ADD: begin bm_s = $signed(b);  cin = 1'b0; end
      OP_SUB: begin bm_s = $signed(~b); cin = 1'b1; end
      OP_DEC: begin bm_s = '1;          cin = 1'b0; end
      OP_INC: begin bm_s = '0;          cin = 1'b1; end
      default: begin bm_s = '0;         cin = 1'b0; end
    endcase
  end

  assign sum_s = a_s + bm_s + $signed({{(WIDTH-1){1'b0}}, cin});

  always_comb begin
    res_d = '0;
    err_d = 1'b0;
    case (op)
      OP_NOT: res_d = ~a_s;
      OP_AND: res_d = a_s & $signed(b);
      OP_OR:  res_d = a_s | $signed(b);
      OP_XOR: res_d = a_s ^ $signed(b);
      default: begin
        res_d = sum_s;
        err_d = ovf_f(a_s, bm_s, sum_s);
      end
    endcase
  end

  // Result register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      res_q <= res_d;
      err_q <= err_d;
    end
  end

  assign res = res_q;
  assign err = err_q;

endmodule

// File: tb/tb_alu6.sv
// Bench for alu6: directed boundary tables plus randomized traffic, checked against an
// integer-arithmetic reference model.
module tb_alu6;

  logic       clk;
  logic       rst;
  logic [5:0] a;
  logic [5:0] b;
  logic [2:0] op;
  logic [5:0] res;
  logic       err;

  int vectors;
  int miscompares;

  alu6 #(.WIDTH(6)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .res(res), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact integer result, then wrap; overflow means the exact value leaves [-32, 31].
  function automatic void model(input logic [5:0] av, input logic [5:0] bv, input logic [2:0] o,
                                output logic [5:0] r, output logic e);
    int sa, sb, x;
    logic [31:0] t;
    sa = int'($signed(av));
    sb = int'($signed(bv));
    x  = 0;
    r  = '0;
    e  = 1'b0;
    case (o)
      3'd0: x = sa + sb;
      3'd1: x = sa - sb;
      3'd2: x = sa - 1;
      3'd3: x = sa + 1;
      default: x = 0;
    endcase
    if (o < 3'd4) begin
      t = x;
      r = t[5:0];
      e = (x > 31) || (x < -32);
    end else begin
      case (o)
        3'd4: r = ~av;
        3'd5: r = av & bv;
        3'd6: r = av | bv;
        default: r = av ^ bv;
      endcase
      e = 1'b0;
    end
  endfunction

  // Drive inputs just after an edge, then sample 1 time unit after the next edge.
  task automatic step(input logic [5:0] av, input logic [5:0] bv, input logic [2:0] o);
    a  = av;
    b  = bv;
    op = o;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a = 6'd0; b = 6'd0; op = 3'd0;
    @(posedge clk); #1;
    vectors++;
    if (res !== 6'd0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_init: res=%b err=%b expected res=000000 err=0", res, err);
    end
    rst = 1'b0;
    step(6'd31, 6'd1, 3'd0);
    vectors++;
    if (res !== 6'b100000 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_preload: res=%b err=%b expected res=100000 err=1", res, err);
    end
    a = 6'd5; b = 6'd6;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (res !== 6'd0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: res=%b err=%b expected res=000000 err=0", res, err);
    end
    @(posedge clk); #1;
    vectors++;
    if (res !== 6'd0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_held: res=%b err=%b expected res=000000 err=0", res, err);
    end
    #2 rst = 1'b0;
    @(negedge clk);
    a = 6'd9; b = 6'd10; op = 3'd0;
    @(posedge clk); #1;
    vectors++;
    if (res !== 6'b010011 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_first: res=%b err=%b expected res=010011 err=0", res, err);
    end
  endtask

  // Directed table entry: a, b, op, expected res, expected err.
  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    logic [2:0] op;
    logic [5:0] r;
    logic       e;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[$];
    tbl = '{
      '{6'd9,   6'h3c,  3'd0, 6'b000101, 1'b0},
      '{6'd9,   6'h35,  3'd0, 6'b111110, 1'b0},
      '{6'h38,  6'h3c,  3'd0, 6'b110100, 1'b0},
      '{6'd16,  6'd23,  3'd0, 6'b100111, 1'b1},
      '{6'd10,  6'd9,   3'd1, 6'b000001, 1'b0},
      '{6'd9,   6'd10,  3'd1, 6'b111111, 1'b0},
      '{6'd9,   6'h3c,  3'd1, 6'b001101, 1'b0},
      '{6'h3c,  6'd9,   3'd1, 6'b110011, 1'b0},
      '{6'h3c,  6'h37,  3'd1, 6'b000101, 1'b0},
      '{6'h30,  6'd23,  3'd1, 6'b011001, 1'b1},
      '{6'd0,   6'h20,  3'd1, 6'b100000, 1'b1},
      '{6'h3f,  6'h20,  3'd1, 6'b011111, 1'b0},
      '{6'd10,  6'd0,   3'd2, 6'b001001, 1'b0},
      '{6'd0,   6'd0,   3'd2, 6'b111111, 1'b0},
      '{6'h36,  6'd0,   3'd2, 6'b110101, 1'b0},
      '{6'h20,  6'd0,   3'd2, 6'b011111, 1'b1},
      '{6'd10,  6'd0,   3'd3, 6'b001011, 1'b0},
      '{6'h3f,  6'd0,   3'd3, 6'b000000, 1'b0},
      '{6'h36,  6'd0,   3'd3, 6'b110111, 1'b0},
      '{6'd31,  6'd0,   3'd3, 6'b100000, 1'b1},
      '{6'h3f,  6'd1,   3'd0, 6'b000000, 1'b0},
      '{6'd0,   6'd1,   3'd1, 6'b111111, 1'b0},
      '{6'h20,  6'd1,   3'd1, 6'b011111, 1'b1},
      '{6'd7,   6'd0,   3'd4, 6'b111000, 1'b0},
      '{6'd31,  6'd1,   3'd0, 6'b100000, 1'b1},
      '{6'd7,   6'h3f,  3'd5, 6'b000111, 1'b0},
      '{6'd31,  6'd1,   3'd0, 6'b100000, 1'b1},
      '{6'd7,   6'd0,   3'd6, 6'b000111, 1'b0},
      '{6'd7,   6'h3f,  3'd7, 6'b111000, 1'b0}
    };
    foreach (tbl[i]) begin
      step(tbl[i].a, tbl[i].b, tbl[i].op);
      vectors++;
      if (res !== tbl[i].r || err !== tbl[i].e) begin
        miscompares++;
        $display("FAIL directed[%0d] op=%0d a=%b b=%b: res=%b err=%b expected res=%b err=%b",
                 i, tbl[i].op, tbl[i].a, tbl[i].b, res, err, tbl[i].r, tbl[i].e);
      end
    end
  endtask

  // Every cycle carries a new op; the previous result must hold until the next edge.
  task automatic test_back_to_back();
    logic [5:0] er, pr, av, bv;
    logic       ee, pe;
    step(6'd1, 6'd1, 3'd0);
    model(6'd1, 6'd1, 3'd0, pr, pe);
    for (int i = 0; i < 24; i++) begin
      av = 6'($urandom);
      bv = 6'($urandom);
      a = av; b = bv; op = 3'(i % 8);
      #2;
      vectors++;
      if (res !== pr || err !== pe) begin
        miscompares++;
        $display("FAIL b2b_hold[%0d]: res=%b err=%b expected res=%b err=%b", i, res, err, pr, pe);
      end
      model(av, bv, 3'(i % 8), er, ee);
      @(posedge clk); #1;
      vectors++;
      if (res !== er || err !== ee) begin
        miscompares++;
        $display("FAIL b2b[%0d] op=%0d a=%b b=%b: res=%b err=%b expected res=%b err=%b",
                 i, i % 8, av, bv, res, err, er, ee);
      end
      pr = er;
      pe = ee;
    end
  endtask

  task automatic test_random();
    logic [5:0] er, av, bv;
    logic [2:0] o;
    logic       ee;
    for (int i = 0; i < 400; i++) begin
      av = 6'($urandom);
      bv = 6'($urandom);
      o  = 3'($urandom_range(0, 7));
      if (i % 16 == 0) av = 6'h20;
      if (i % 16 == 1) av = 6'h1f;
      if (i % 16 == 2) bv = 6'h20;
      model(av, bv, o, er, ee);
      step(av, bv, o);
      vectors++;
      if (res !== er || err !== ee) begin
        miscompares++;
        $display("FAIL random[%0d] op=%0d a=%b b=%b: res=%b err=%b expected res=%b err=%b",
                 i, o, av, bv, res, err, er, ee);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu6.md
Name: alu6

Overview:
- Registered 6-bit two's-complement arithmetic/logic unit.
- Selects one of eight operations (add, sub, decrement, increment, NOT, AND, OR, XOR) via a 3-bit opcode.
- Registers the result and a signed-overflow error flag on the rising clock edge.
- Used as the datapath execution element: operands and opcode are driven by control logic, and the result/flag are consumed one cycle later.

Parameters:
- WIDTH, 6, operand/result width in bits; all operands are two's-complement signed, range [-2^(WIDTH-1), 2^(WIDTH-1)-1] = [-32, 31] at the default.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- a  input  WIDTH  operand A, signed two's complement
- b  input  WIDTH  operand B, signed two's complement; ignored for opcodes 2, 3, 4
- op  input  3  operation select
- res  output  WIDTH  registered result
- err  output  1  registered signed-overflow flag

Behaviour:
- Reset: rst high clears res to 0 and err to 0 immediately, independent of clk. Outputs stay 0 while rst is held. The first update occurs on the first rising clk edge after rst deasserts.
- Latency: 1 cycle. On each rising clk edge (rst low), res/err load the function of the a, b, op values present just before that edge.
- No handshake. Inputs are sampled every cycle, and outputs update every cycle.
- Opcodes, with R computed modulo 2^WIDTH:
  - 000 ADD: R = a + b
  - 001 SUB: R = a - b, implemented as a + ~b + 1
  - 010 DEC: R = a - 1
  - 011 INC: R = a + 1
  - 100 NOT: R = ~a
  - 101 AND: R = a & b
  - 110 OR: R = a | b
  - 111 XOR: R = a ^ b
- Arithmetic opcodes (000–011) share one WIDTH-bit adder. Operand B is muxed as b, ~b, all-ones, or zero, with carry-in 0, 1, 0, 1 respectively.
- err is set for arithmetic opcodes when a signed overflow occurs: both adder inputs have the same sign and the sum sign differs. Equivalently, carry into MSB XOR carry out of MSB.
- err is always 0 for logic opcodes (100–111).
- On overflow, res holds the wrapped low WIDTH bits of the exact result; there is no saturation.
- Boundaries:
  - 31+1 → res 100000, err 1
  - -32-1 → res 011111, err 1
  - -1+1 → res 000000, err 0
  - 0-1 → res 111111, err 0
  - SUB with b = -32: overflow is flagged per the carry rule (e.g. 0 - (-32) → res 100000, err 1; -1 - (-32) → 31, err 0).
- op or operand changes mid-cycle have no effect until the next edge.
- Reset asserted mid-operation discards any pending result.
- X/unused bits: none. All 8 opcodes are defined.

Test Plan:
- Reset: assert rst asynchronously between edges → res=000000, err=0 immediately. Deassert; op=000, a=9, b=10 → after 1 edge res=010011 (19), err=0.
- ADD: 9+(-4) → 000101, err 0. 9+(-11) → 111110 (-2), err 0. -8+(-4) → 110100 (-12), err 0. 16+23 → 100111 (wrapped), err 1.
- SUB: 10-9 → 000001. 9-10 → 111111 (-1). 9-(-4) → 001101 (13). -4-9 → 110011 (-13). -4-(-9) → 000101. -16-23 → 011001 (wrapped), err 1. All others err 0.
- DEC/INC: DEC 10 → 9, DEC 0 → 111111, DEC -10 → 110101 (-11), DEC -32 → 011111 err 1. INC 10 → 11, INC -1 → 0, INC -10 → 110111 (-9), INC 31 → 100000 err 1.
- Logic: NOT 000111 → 111000. AND 000111&111111 → 000111. OR 000111|000000 → 000111. XOR 000111^111111 → 111000. err=0 for all, including when a preceding overflow left err=1.
- Latency/back-to-back: change op/a/b every cycle across all 8 opcodes → each result appears exactly one edge later, with no skipped or duplicated cycles.
